// File: rtl/rf_pkg.sv
// Shared constants and state encoding for the multiport register file.
package rf_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SWEEP = 1'b1;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 3;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SWEEP = ST_SWEEP
  } rf_state_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: selects storage or a same-edge bypass value,
// then registers data and raises a one-cycle valid strobe.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W    = RF_DATA_W,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int DEPTH     = 2**ADDR_W,
  parameter int ZERO_REG0 = 0
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    re,
  input  logic [ADDR_W-1:0]       r_addr,
  input  logic [DEPTH*DATA_W-1:0] mem_flat,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       w_addr,
  input  logic [DATA_W-1:0]       w_data,
  input  logic                    sw_en,
  input  logic [ADDR_W-1:0]       sw_addr,
  output logic [DATA_W-1:0]       r_data,
  output logic                    r_valid
);

  logic [DATA_W-1:0] rd_val;

  // Later assignments win: hardwired zero beats write bypass beats sweep bypass.
  always_comb begin
    rd_val = mem_flat[r_addr*DATA_W +: DATA_W];
    if (sw_en && (sw_addr == r_addr))
      rd_val = '0;
    if (wr_en && (w_addr == r_addr))
      rd_val = w_data;
    if ((ZERO_REG0 != 0) && (r_addr == '0))
      rd_val = '0;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= re;
      if (re)
        r_data <= rd_val;
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// Register file with one write port, two registered read ports with bypass,
// and a zeroize sweep that back-pressures writes while it runs.
//
// state | meaning
// IDLE  | writes accepted, waiting for zero_req
// SWEEP | clearing reg[cnt] each cycle, writes stalled
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W    = RF_DATA_W,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int DEPTH     = 2**ADDR_W,
  parameter int ZERO_REG0 = 0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  output logic              w_ready,
  input  logic              re0,
  input  logic [ADDR_W-1:0] rAddr0,
  output logic [DATA_W-1:0] rData0,
  output logic              rvalid0,
  input  logic              re1,
  input  logic [ADDR_W-1:0] rAddr1,
  output logic [DATA_W-1:0] rData1,
  output logic              rvalid1,
  input  logic              zero_req,
  output logic              busy
);

  if (DEPTH != 2**ADDR_W) begin : g_depth_check
    $error("rf_multiport: DEPTH must equal 2**ADDR_W");
  end

  rf_state_t         state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              wr_acc;
  logic              sw_en;

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH*DATA_W-1:0] mem_flat;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    w_ready   = 1'b0;
    case (state)
      IDLE: begin
        w_ready = 1'b1;
        if (zero_req) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        busy    = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == ADDR_W'(DEPTH - 1))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_acc = we && w_ready;
  assign sw_en  = (state == SWEEP);

  // An accepted write to a hardwired-zero register 0 is simply not stored.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (sw_en) begin
      mem[cnt] <= '0;
    end else if (wr_acc && !((ZERO_REG0 != 0) && (wAddr == '0))) begin
      mem[wAddr] <= wData;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*DATA_W +: DATA_W] = mem[g];
  end

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_REG0(ZERO_REG0)
  ) u_rd0 (
    .clk     (clk),
    .clear   (clear),
    .re      (re0),
    .r_addr  (rAddr0),
    .mem_flat(mem_flat),
    .wr_en   (wr_acc),
    .w_addr  (wAddr),
    .w_data  (wData),
    .sw_en   (sw_en),
    .sw_addr (cnt),
    .r_data  (rData0),
    .r_valid (rvalid0)
  );

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_REG0(ZERO_REG0)
  ) u_rd1 (
    .clk     (clk),
    .clear   (clear),
    .re      (re1),
    .r_addr  (rAddr1),
    .mem_flat(mem_flat),
    .wr_en   (wr_acc),
    .w_addr  (wAddr),
    .w_data  (wData),
    .sw_en   (sw_en),
    .sw_addr (cnt),
    .r_data  (rData1),
    .r_valid (rvalid1)
  );

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
- Parametrised next-generation register file: one write port, two independent read ports, registered reads with valid strobes, and write-to-read bypass.
- Adds a sequenced zeroize sweep (FSM plus counter) with write back-pressure.
- Optionally hardwires register 0 to zero.
- Drop-in storage for the datapath wherever an 8x32 single-read file was used; the second read port feeds two-operand ALU paths.

Parameters:
DATA_W, 32, width of each register
ADDR_W, 3, address width
DEPTH, 2**ADDR_W, number of registers (must equal 2**ADDR_W)
ZERO_REG0, 0, 1 = register 0 reads as zero and ignores writes

Ports:
clk  in  1  system clock, all state on rising edge
clear  in  1  asynchronous active-high reset
we  in  1  write request
wAddr  in  ADDR_W  write address
wData  in  DATA_W  write data
w_ready  out  1  write accepted this cycle when we && w_ready
re0  in  1  read request, port 0
rAddr0  in  ADDR_W  read address, port 0
rData0  out  DATA_W  registered read data, port 0
rvalid0  out  1  rData0 valid strobe
re1  in  1  read request, port 1
rAddr1  in  ADDR_W  read address, port 1
rData1  out  DATA_W  registered read data, port 1
rvalid1  out  1  rData1 valid strobe
zero_req  in  1  request zeroize sweep of all registers
busy  out  1  sweep in progress

Behaviour:
- Reset (clear=1, asynchronous, active-high, on clk/clear as fixed): all registers 0; rData0 = rData1 = 0; rvalid0 = rvalid1 = 0; state IDLE; sweep counter 0; busy = 0; w_ready = 1.
- FSM states IDLE and SWEEP.
  - IDLE -> SWEEP on zero_req=1; counter loads 0.
  - In SWEEP, each edge: reg[cnt] <= 0, cnt <= cnt+1.
  - SWEEP -> IDLE on the edge where cnt == DEPTH-1. The sweep lasts exactly DEPTH cycles.
  - zero_req while in SWEEP is ignored (no restart, no extension).
- Outputs busy = (state==SWEEP) and w_ready = (state==IDLE). Both are combinational from state, with no input dependence.
- Write: at an edge with we && w_ready, reg[wAddr] <= wData.
  - If ZERO_REG0=1 and wAddr=0, the write is accepted but discarded.
  - we while w_ready=0 is dropped; the producer must hold the request until it is accepted.
- Write and zero_req in the same IDLE cycle: the write is accepted. The sweep then begins next cycle and later clears that register.
- Read, 1-cycle latency: at an edge with re_k=1, rData_k <= value(rAddr_k) and rvalid_k <= 1. At an edge with re_k=0, rvalid_k <= 0 and rData_k holds its last value.
- value(a) priority:
  1. 0 if ZERO_REG0 && a==0.
  2. Else wData if a write to a is accepted at the same edge (write bypass).
  3. Else 0 if SWEEP is clearing a at the same edge (sweep bypass).
  4. Else reg[a].
- Both ports may read the same address, including the write address, in the same cycle; both return identical data.
- Reads are permitted during SWEEP. Registers not yet swept return their old contents.
- clear asserted mid-sweep aborts the sweep immediately; all registers 0, state IDLE.
- Address wrap: not applicable, since DEPTH = 2**ADDR_W and every address is valid.

Decomposition:
- Shared package (rf_pkg): state encoding localparams (ST_IDLE=1'b0, ST_SWEEP=1'b1) and default DATA_W/ADDR_W constants for datapath users.
- One sub-module: rf_read_port (address, bypass compare, output register, valid strobe), instantiated twice.
- Storage array, write decode and the sweep FSM live in the top module.

Test Plan:
- Reset then basic write/read: clear pulse; write 32'hDEADBEEF to addr 5; next cycle re0=1, rAddr0=5 -> one cycle later rData0=32'hDEADBEEF, rvalid0=1 for exactly one cycle.
- Dual read: regs 2=32'h11, 3=32'h22; re0/re1 same cycle with rAddr0=2, rAddr1=3 -> rData0=32'h11, rData1=32'h22, both rvalid=1.
- Write bypass: write 32'hA5A5A5A5 to addr 4 while re0=1, rAddr0=4 and re1=1, rAddr1=4 in the same cycle -> both ports return 32'hA5A5A5A5 next cycle.
- Sweep with back-pressure: fill all 8 regs with nonzero data; pulse zero_req -> busy=1 and w_ready=0 for exactly 8 cycles. A we=1 to addr 6 with 32'h77 during the sweep is dropped. Afterwards, all 8 regs read 0 and busy=0.
- ZERO_REG0=1 build: write 32'hFFFFFFFF to addr 0 -> read of addr 0 returns 0 on both ports. Write and read of addr 1 behave normally.
- Reset mid-sweep: assert clear on sweep cycle 3 -> outputs immediately at reset values, w_ready=1. A read after deassertion returns 0 from every register.
